coef_loader: RTL

COEF_LOADER -- requirements
Module: coef_loader

---
 rtl/coef_loader.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/coef_loader.sv
// Streams one polynomial of N coefficients into four conflict-free banks, one 4-wide write per group.
// Optional build macro RANGE_CHECK_EN: reduce coefficients >= q by q and raise the sticky range_err flag.
module coef_loader #(
  parameter int DATA_W = 24,
  parameter int N      = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              KD_mode,
  input  logic              load_req,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [3:0]        bank_wen,
  output logic [6:0]        bank_addr,
  output logic [DATA_W-1:0] bank_d0,
  output logic [DATA_W-1:0] bank_d1,
  output logic [DATA_W-1:0] bank_d2,
  output logic [DATA_W-1:0] bank_d3,
  output logic              busy,
  output logic              load_done,
  output logic              range_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam logic [7:0] LAST_IDX = 8'(N - 1);

  // Digit-sum of the base-4 index: consecutive indices of a group land in distinct banks.
  function automatic logic [1:0] bank_of(input logic [7:0] i);
    return i[1:0] + i[3:2] + i[5:4] + i[7:6];
  endfunction

  function automatic logic [DATA_W-1:0] mask_coef(input logic [DATA_W-1:0] d, input logic kd);
    logic [DATA_W-1:0] m;
    m = kd ? d : {{(DATA_W-12){1'b0}}, d[11:0]};
    return m;
  endfunction

`ifdef RANGE_CHECK_EN
  function automatic logic [DATA_W-1:0] modulus(input logic kd);
    return kd ? DATA_W'(24'd8380417) : DATA_W'(24'd3329);
  endfunction

  function automatic logic out_of_range(input logic [DATA_W-1:0] d, input logic kd);
    return mask_coef(d, kd) >= modulus(kd);
  endfunction

  function automatic logic [DATA_W-1:0] store_coef(input logic [DATA_W-1:0] d, input logic kd);
    logic [DATA_W-1:0] m;
    m = mask_coef(d, kd);
    return (m >= modulus(kd)) ? (m - modulus(kd)) : m;
  endfunction
`else
  function automatic logic [DATA_W-1:0] store_coef(input logic [DATA_W-1:0] d, input logic kd);
    return mask_coef(d, kd);
  endfunction
`endif

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [7:0]        idx_r;
  logic              kd_r;
  logic              in_ready_r;
  logic              busy_r;
  logic              load_done_r;
  logic [3:0]        bank_wen_r;
  logic [6:0]        bank_addr_r;
  logic [DATA_W-1:0] stage_r  [4];
  logic [DATA_W-1:0] bank_d_r [4];
  logic              accept_s;
  logic              last_s;
  logic              start_s;
  logic              group_end_s;
  logic [1:0]        bank_s;
  logic [DATA_W-1:0] coef_s;

  assign accept_s    = in_valid && (state_r == LOAD);
  assign last_s      = accept_s && (idx_r == LAST_IDX);
  assign start_s     = load_req && (state_r == IDLE);
  assign group_end_s = accept_s && (idx_r[1:0] == 2'd3);
  assign bank_s      = bank_of(idx_r);
  assign coef_s      = store_coef(in_data, kd_r);

  // Next-state logic of the load sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_req) begin
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        if (last_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = LOAD;
        end
      end
      DRAIN:   state_nxt_s = DONE;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, index, latched mode and status outputs; status is registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      idx_r       <= 8'd0;
      kd_r        <= 1'b0;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      load_done_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == LOAD);
      busy_r      <= (state_nxt_s != IDLE);
      load_done_r <= (state_nxt_s == DONE);
      if (start_s) begin
        kd_r  <= KD_mode;
        idx_r <= 8'd0;
      end else if (accept_s) begin
        idx_r <= last_s ? 8'd0 : idx_r + 8'd1;
      end
    end
  end

  // Per-bank staging; the output registers form the second buffer so staging never stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_wen_r  <= 4'h0;
      bank_addr_r <= 7'd0;
      for (int k = 0; k < 4; k++) begin
        stage_r[k]  <= {DATA_W{1'b0}};
        bank_d_r[k] <= {DATA_W{1'b0}};
      end
    end else begin
      bank_wen_r <= group_end_s ? 4'hF : 4'h0;
      if (accept_s) begin
        stage_r[bank_s] <= coef_s;
      end
      if (group_end_s) begin
        bank_addr_r <= {1'b0, idx_r[7:2]};
        for (int k = 0; k < 4; k++) begin
          bank_d_r[k] <= (bank_s == 2'(k)) ? coef_s : stage_r[k];
        end
      end
    end
  end

`ifdef RANGE_CHECK_EN
  logic range_err_r;

  // Sticky out-of-range flag, cleared by a new load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      range_err_r <= 1'b0;
    end else if (start_s) begin
      range_err_r <= 1'b0;
    end else if (accept_s && out_of_range(in_data, kd_r)) begin
      range_err_r <= 1'b1;
    end
  end

  assign range_err = range_err_r;
`else
  assign range_err = 1'b0;
`endif

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign load_done = load_done_r;
  assign bank_wen  = bank_wen_r;
  assign bank_addr = bank_addr_r;
  assign bank_d0   = bank_d_r[0];
  assign bank_d1   = bank_d_r[1];
  assign bank_d2   = bank_d_r[2];
  assign bank_d3   = bank_d_r[3];

endmodule
